// File: rtl/us64_pkg.sv
// Geometry constants and shared types for the 4x line-replicating upscaler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package us64_pkg;

    localparam int PIX_W  = 8;     // pixel width
    localparam int IN_W   = 64;    // low-res pixels per row
    localparam int OUT_W  = 256;   // high-res pixels per row
    localparam int REP    = 4;     // horizontal and vertical scale factor
    localparam int ADDR_W = 6;     // log2(IN_W)
    localparam int X_W    = 8;     // log2(OUT_W)
    localparam int Y_W    = 2;     // log2(REP)

    typedef logic              bank_t;   // ping-pong bank index
    typedef logic [ADDR_W-1:0] addr_t;   // column address inside one bank
    typedef logic [PIX_W-1:0]  pix_t;

endpackage

// File: rtl/us64_rep_if.sv
// Handshake bundle for us64_rep: low-res pixel stream in, high-res pixel stream out.
// Latency: n/a (wiring only).
// Backpressure: din_ready / dout_ready, transfer on valid && ready.
// Ports: din, din_valid, din_ready (fill side); dout, dout_valid, dout_ready,
//        dout_sol, dout_eol (emit side). master = source/sink, slave = the upscaler.
interface us64_rep_if;

    logic [us64_pkg::PIX_W-1:0] din;
    logic                       din_valid;
    logic                       din_ready;
    logic [us64_pkg::PIX_W-1:0] dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic                       dout_sol;
    logic                       dout_eol;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, dout_sol, dout_eol
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, dout_sol, dout_eol
    );

endinterface

// File: rtl/us64_line_bank.sv
// Two-bank x 64-entry pixel line store, one synchronous write port, async read port A.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller owns bank occupancy.
// Ports: clk, wr_en_i/wr_bank_i/wr_addr_i/wr_dat_i (write), rd_bank_i/rd_addr_a_i/rd_dat_a_o
//        (read A); rd_addr_b_i/rd_dat_b_o exist only when US64_HINTERP_EN is defined.
module us64_line_bank
    import us64_pkg::*;
(
    input  logic  clk,
    input  logic  wr_en_i,
    input  bank_t wr_bank_i,
    input  addr_t wr_addr_i,
    input  pix_t  wr_dat_i,
    input  bank_t rd_bank_i,
    input  addr_t rd_addr_a_i,
    output pix_t  rd_dat_a_o
`ifdef US64_HINTERP_EN
    ,
    input  addr_t rd_addr_b_i,
    output pix_t  rd_dat_b_o
`endif
);

    // No reset: a bank is only read after it has been completely rewritten.
    pix_t mem_q [2][IN_W];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_a_o = mem_q[rd_bank_i][rd_addr_a_i];

`ifdef US64_HINTERP_EN
    assign rd_dat_b_o = mem_q[rd_bank_i][rd_addr_b_i];
`endif

endmodule

// File: rtl/us64_rep.sv
// 4x upscaler: 64-pixel rows in, each pixel repeated 4x across and each row 4x down (256-wide out).
// Latency: first output loads one cycle after the 64th input of a row when no output is pending.
// Backpressure: din_ready low while the write bank is full; dout/sol/eol hold while dout_ready low.
// Ports: clk, rst_n (async, active-low), io (us64_rep_if.slave).
// Build option: US64_HINTERP_EN swaps horizontal replication for 2-tap linear interpolation.
module us64_rep
    import us64_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    us64_rep_if.slave io
);

    logic [1:0]     full_q, full_d;
    bank_t          wbank_q, wbank_d;
    bank_t          rbank_q, rbank_d;
    addr_t          in_addr_q, in_addr_d;
    logic [X_W-1:0] x_out_q, x_out_d;
    logic [Y_W-1:0] y_rep_q, y_rep_d;
    pix_t           dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           dout_sol_q, dout_sol_d;
    logic           dout_eol_q, dout_eol_d;

    logic  wr_fire;
    logic  last_in;
    logic  load;
    logic  last_col;
    logic  last_load;
    addr_t col_a;
    pix_t  pix_a;
    pix_t  pix;

    assign io.din_ready = ~full_q[wbank_q];
    assign wr_fire      = io.din_valid && io.din_ready;
    assign last_in      = (in_addr_q == addr_t'(IN_W - 1));

    // Load a new output whenever a full bank exists and the output register is free or draining.
    assign load      = full_q[rbank_q] && (!dout_valid_q || io.dout_ready);
    assign last_col  = (x_out_q == X_W'(OUT_W - 1));
    assign last_load = load && last_col && (y_rep_q == Y_W'(REP - 1));

    // Each input column covers REP output columns.
    assign col_a = x_out_q[X_W-1:2];

`ifdef US64_HINTERP_EN
    addr_t            col_b;
    pix_t             pix_b;
    logic [2:0]       w_a;
    logic [2:0]       w_b;
    logic [PIX_W+1:0] mix;

    // Right neighbour clamps at the last column so the row edge replicates.
    assign col_b = (col_a == addr_t'(IN_W - 1)) ? col_a : col_a + addr_t'(1);
    assign w_b   = {1'b0, x_out_q[1:0]};
    assign w_a   = 3'd4 - w_b;
    // Weights sum to 4, so the 10-bit sum never overflows before the >>2.
    assign mix   = ({2'b00, pix_a} * {7'd0, w_a}) + ({2'b00, pix_b} * {7'd0, w_b});
    assign pix   = mix[PIX_W+1:2];
`else
    assign pix   = pix_a;
`endif

    us64_line_bank u_bank (
        .clk         (clk),
        .wr_en_i     (wr_fire),
        .wr_bank_i   (wbank_q),
        .wr_addr_i   (in_addr_q),
        .wr_dat_i    (io.din),
        .rd_bank_i   (rbank_q),
        .rd_addr_a_i (col_a),
        .rd_dat_a_o  (pix_a)
`ifdef US64_HINTERP_EN
        ,
        .rd_addr_b_i (col_b),
        .rd_dat_b_o  (pix_b)
`endif
    );

    always_comb begin
        full_d       = full_q;
        wbank_d      = wbank_q;
        rbank_d      = rbank_q;
        in_addr_d    = in_addr_q;
        x_out_d      = x_out_q;
        y_rep_d      = y_rep_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_sol_d   = dout_sol_q;
        dout_eol_d   = dout_eol_q;

        if (wr_fire) begin
            in_addr_d = in_addr_q + addr_t'(1);   // wraps 63 -> 0 by width
            if (last_in) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        // A set and a clear in the same cycle always hit different banks:
        // the set needs full[wbank]==0, the clear needs full[rbank]==1.
        if (load) begin
            dout_d       = pix;
            dout_valid_d = 1'b1;
            dout_sol_d   = (x_out_q == '0);
            dout_eol_d   = last_col;
            x_out_d      = x_out_q + X_W'(1);
            if (last_col) begin
                y_rep_d = y_rep_q + Y_W'(1);
            end
            if (last_load) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
            end
        end else if (io.dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q       <= '0;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            in_addr_q    <= '0;
            x_out_q      <= '0;
            y_rep_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sol_q   <= 1'b0;
            dout_eol_q   <= 1'b0;
        end else begin
            full_q       <= full_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            in_addr_q    <= in_addr_d;
            x_out_q      <= x_out_d;
            y_rep_q      <= y_rep_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_sol_q   <= dout_sol_d;
            dout_eol_q   <= dout_eol_d;
        end
    end

    assign io.dout       = dout_q;
    assign io.dout_valid = dout_valid_q;
    assign io.dout_sol   = dout_sol_q;
    assign io.dout_eol   = dout_eol_q;

endmodule

// File: tb/tb_us64_rep.sv
// Bench for us64_rep: directed steps plus random rows, checked against a row-level reference.
// Latency: n/a.
// Backpressure: dout_ready driven always-high, random, or held low per step.
module tb_us64_rep;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    us64_rep_if bus ();

    us64_rep dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rdy_mode    = 0;   // 0: ready high, 1: random, 2: held low

    logic [7:0] rows [32][64];   // every row handed to the DUT, in order
    int         rows_sent = 0;

    // Reference-side output tracking
    int         ridx     = 0;    // row currently being emitted
    int         pos_in   = 0;    // output index within that row's 1024 pixels
    int         tot      = 0;    // total outputs transferred
    int         last_cyc = 0;    // cycle of the most recent load that was transferred
    int         mx       = 0;
    logic [7:0] obs [4096];
    bit         stall_q  = 1'b0;
    logic [9:0] hold_v   = '0;

    // Expected high-res pixel at output column x of stored row r.
    function automatic logic [7:0] ref_pix(input int r, input int x);
        int c;
        c = x / 4;
`ifdef US64_HINTERP_EN
        begin
            int c2, p, acc;
            p   = x % 4;
            c2  = (c == 63) ? 63 : c + 1;
            acc = (int'(rows[r][c]) * (4 - p) + int'(rows[r][c2]) * p) / 4;
            return 8'(acc);
        end
`else
        return rows[r][c];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic die(input string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", tag);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "aborting after %s", tag);
    endtask

    // kind 0: ramp 4*i, kind 1: constant val, kind 2: random
    task automatic post_row(input int kind, input int val, output int r);
        r = rows_sent;
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0:       rows[r][i] = 8'(4 * i);
                1:       rows[r][i] = 8'(val);
                default: rows[r][i] = 8'($urandom_range(0, 255));
            endcase
        end
        rows_sent++;
    endtask

    task automatic send_row(input int r, input bit gaps, output int waits,
                            output int k_first, output int k_last);
        int w;
        waits   = 0;
        k_first = 0;
        k_last  = 0;
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin
                bus.din_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.din       = rows[r][i];
            bus.din_valid = 1'b1;
            w = 0;
            while (!bus.din_ready) begin
                if (w == 3000) die("din_stall");
                @(posedge clk);
                #1;
                w++;
            end
            @(posedge clk);
            #1;
            waits += w;
            if (i == 0)  k_first = cyc;
            if (i == 63) k_last  = cyc;
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (ridx != rows_sent) begin
            if (n == budget) die("drain");
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_tot(input int base, input int n, input int budget);
        int k;
        k = 0;
        while (!((tot - base) >= n && bus.dout_valid)) begin
            if (k == budget) die("wait_output");
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        int r, w, w1, w2, kf, kl, k1, base;
        logic [9:0] cap;

        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(posedge clk);
                #2;
                case (rdy_mode)
                    0:       bus.dout_ready = 1'b1;
                    1:       bus.dout_ready = ($urandom_range(0, 3) != 0);
                    default: bus.dout_ready = 1'b0;
                endcase
            end
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    ridx    = rows_sent;
                    pos_in  = 0;
                    stall_q = 1'b0;
                end else begin
                    if (stall_q)
                        check("hold", 32'({bus.dout_valid, bus.dout_sol, bus.dout_eol, bus.dout}),
                              32'({1'b1, hold_v}));
                    if (bus.dout_valid && bus.dout_ready) begin
                        if (ridx >= rows_sent) begin
                            vectors++;
                            miscompares++;
                            $error("FAIL extra_out: observed pixel %0h with no row outstanding", bus.dout);
                        end else begin
                            mx = pos_in % 256;
                            check("pix", 32'({bus.dout_sol, bus.dout_eol, bus.dout}),
                                  32'({mx == 0, mx == 255, ref_pix(ridx, mx)}));
                            obs[tot % 4096] = bus.dout;
                            last_cyc = cyc;
                            tot++;
                            pos_in++;
                            if (pos_in == 1024) begin
                                pos_in = 0;
                                ridx++;
                            end
                        end
                    end
                    stall_q = bus.dout_valid && !bus.dout_ready;
                    hold_v  = {bus.dout_sol, bus.dout_eol, bus.dout};
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout",  32'(bus.dout), 0);
        check("rst_valid", 32'(bus.dout_valid), 0);
        check("rst_sol",   32'(bus.dout_sol), 0);
        check("rst_eol",   32'(bus.dout_eol), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_din_ready", 32'(bus.din_ready), 1);

        // Replication ramp and first-output latency
        rdy_mode = 0;
        post_row(0, 0, r);
        base = tot;
        send_row(r, 1'b0, w, kf, kl);
        check("lat_pre_valid", 32'(bus.dout_valid), 0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(bus.dout_valid), 1);
        check("lat_dout",  32'(bus.dout), 32'(rows[r][0]));
        check("lat_sol",   32'(bus.dout_sol), 1);
        drain(3000);
`ifdef US64_HINTERP_EN
        check("x5", 32'(obs[(base + 5) % 4096]), 5);
        check("x6", 32'(obs[(base + 6) % 4096]), 6);
`else
        check("x5", 32'(obs[(base + 5) % 4096]), 4);
        check("x6", 32'(obs[(base + 6) % 4096]), 4);
`endif
        check("x255", 32'(obs[(base + 255) % 4096]), 252);
        check("ramp_count", tot - base, 1024);

        // Ping-pong: three constant rows back-to-back
        post_row(1, 10, r);
        send_row(r, 1'b0, w1, kf, k1);
        post_row(1, 20, r);
        send_row(r, 1'b0, w2, kf, kl);
        check("pp_no_stall", w1 + w2, 0);
        check("pp_rdy_drop", 32'(bus.din_ready), 0);
        post_row(1, 30, r);
        send_row(r, 1'b0, w, kf, kl);
        check("pp_rdy_rise", kf - k1, 1025);
        drain(5000);
        check("pp_no_bubble", last_cyc - k1, 3072);

        // Backpressure mid-row at x=100
        post_row(2, 0, r);
        base = tot;
        send_row(r, 1'b0, w, kf, kl);
        wait_tot(base, 100, 3000);
        rdy_mode = 2;
        cap = {bus.dout_sol, bus.dout_eol, bus.dout};
        repeat (10) @(posedge clk);
        #1;
        check("bp_hold", 32'({bus.dout_valid, bus.dout_sol, bus.dout_eol, bus.dout}), 32'({1'b1, cap}));
        check("bp_no_xfer", tot - base, 100);
        rdy_mode = 0;
        drain(3000);
        check("bp_row_count", tot - base, 1024);

        // Reset in the middle of emitting a row
        post_row(1, 50, r);
        base = tot;
        send_row(r, 1'b0, w, kf, kl);
        wait_tot(base, 500, 3000);
        rst_n = 1'b0;
        #1;
        check("rst2_dout",      32'(bus.dout), 0);
        check("rst2_valid",     32'(bus.dout_valid), 0);
        check("rst2_sol",       32'(bus.dout_sol), 0);
        check("rst2_eol",       32'(bus.dout_eol), 0);
        check("rst2_din_ready", 32'(bus.din_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        post_row(1, 7, r);
        base = tot;
        send_row(r, 1'b0, w, kf, kl);
        drain(3000);
        check("rst2_row_count", tot - base, 1024);
        check("rst2_first_pix", 32'(obs[base % 4096]), 7);

        // Random rows with input gaps and random output backpressure
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            post_row(2, 0, r);
            send_row(r, 1'b1, w, kf, kl);
        end
        drain(20000);
        rdy_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
